// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Funct3 size encodings mirror the DMCtrl field driven by the control unit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_DM = 2'd2
  } arb_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Instruction fetch is always a full-word access.
  localparam logic [2:0] FETCH_CTRL = LW;

  // Wide enough for the largest legal STARVE_MAX (15).
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_port_arbiter.
// slave: the arbiter's view; master: requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_ctrl;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_ctrl;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_ctrl, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_en, mem_we, mem_ctrl, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_ctrl, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_ctrl, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Fixed memory-latency down-counter: loads MEM_LAT on grant, counts down while
// an access is in flight; done marks the cycle memory read data is valid.
module mem_arb_lat_counter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);
  localparam int unsigned     CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Define MEM_ARB_STARVE_EN to let fetch win after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state, state_n;
  logic              grant_if, grant_dm;
  logic              lat_done;
  logic              fetch_wins;

  logic              mem_en_q, mem_we_q;
  logic [2:0]        mem_ctrl_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dm_req && !(bus.if_req && fetch_wins)) begin
          grant_dm = 1'b1;
          state_n  = ACC_DM;
        end else if (bus.if_req) begin
          grant_if = 1'b1;
          state_n  = ACC_IF;
        end
      end
      ACC_IF, ACC_DM: begin
        if (lat_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  mem_arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (grant_if | grant_dm),
    .dec  (state != IDLE),
    .done (lat_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= grant_if | grant_dm;
      if (grant_dm) begin
        mem_we_q    <= bus.dm_we;
        mem_ctrl_q  <= bus.dm_ctrl;
        mem_addr_q  <= bus.dm_addr;
        mem_wdata_q <= bus.dm_wdata;
      end else if (grant_if) begin
        mem_we_q   <= 1'b0;
        mem_ctrl_q <= FETCH_CTRL;
        mem_addr_q <= bus.if_addr;
      end
    end
  end

`ifdef MEM_ARB_STARVE_EN
  localparam logic [STARVE_W-1:0] STARVE_CAP = STARVE_W'(STARVE_MAX);
  logic [STARVE_W-1:0] starve_cnt;

  // Counts data grants that bypassed a waiting fetch; saturates at the cap.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && bus.if_req && starve_cnt != STARVE_CAP) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  assign fetch_wins = (starve_cnt == STARVE_CAP);
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign fetch_wins        = 1'b0;
`endif

  // Ready is decoded from registered state only; read data is passed through
  // from memory in that cycle and held at zero otherwise.
  assign bus.if_ready  = (state == ACC_IF) && lat_done;
  assign bus.dm_ready  = (state == ACC_DM) && lat_done;
  assign bus.if_rdata  = bus.if_ready ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_ready ? bus.mem_rdata : '0;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;

endmodule
